// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep sequencer for a combinational Skolem-function candidate.
// Optional macro SKOLEM_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first failure.
module skolem_sweep_ctrl #(
  parameter int NUM_IN        = 5,
  parameter int NUM_OUT       = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [NUM_IN-1:0]  x_out,
  input  logic [NUM_OUT-1:0] y_in,
  input  logic               spec_ok,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               pass,
  output logic [NUM_IN:0]    fail_cnt,
  output logic [NUM_IN-1:0]  first_fail_x,
  output logic [NUM_OUT-1:0] first_fail_y,
  output logic               fail_seen
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [NUM_IN-1:0] X_LAST = '1;
  localparam state_e FIRST_ST =
    (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_IN-1:0]   x_q, x_d;
  logic [NUM_IN:0]     fcnt_q, fcnt_d;
  logic [NUM_IN-1:0]   ffx_q, ffx_d;
  logic [NUM_OUT-1:0]  ffy_q, ffy_d;
  logic                seen_q, seen_d;
  logic                pass_q, pass_d;
  logic                abrt_q, abrt_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    fcnt_d  = fcnt_q;
    ffx_d   = ffx_q;
    ffy_d   = ffy_q;
    seen_d  = seen_q;
    pass_d  = pass_q;
    abrt_d  = abrt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          x_d     = '0;
          fcnt_d  = '0;
          ffx_d   = '0;
          ffy_d   = '0;
          seen_d  = 1'b0;
          pass_d  = 1'b0;
          abrt_d  = 1'b0;
          cnt_d   = SETTLE_INIT;
          state_d = FIRST_ST;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          abrt_d  = 1'b1;
          pass_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == 8'd1) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          // the coinciding verdict is dropped
          state_d = S_IDLE;
          abrt_d  = 1'b1;
          pass_d  = 1'b0;
        end else begin
          if (!spec_ok) begin
            fcnt_d = fcnt_q + 1'b1;
            if (!seen_q) begin
              ffx_d  = x_q;
              ffy_d  = y_in;
              seen_d = 1'b1;
            end
          end
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
          if (!spec_ok || x_q == X_LAST) begin
            state_d = S_DONE;
          end else begin
            x_d     = x_q + 1'b1;
            cnt_d   = SETTLE_INIT;
            state_d = FIRST_ST;
          end
`else
          if (x_q == X_LAST) begin
            state_d = S_DONE;
          end else begin
            x_d     = x_q + 1'b1;
            cnt_d   = SETTLE_INIT;
            state_d = FIRST_ST;
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort) begin
          abrt_d = 1'b1;
          pass_d = 1'b0;
        end else begin
          done_d = 1'b1;
          pass_d = (fcnt_q == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      fcnt_q  <= '0;
      ffx_q   <= '0;
      ffy_q   <= '0;
      seen_q  <= 1'b0;
      pass_q  <= 1'b0;
      abrt_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      fcnt_q  <= fcnt_d;
      ffx_q   <= ffx_d;
      ffy_q   <= ffy_d;
      seen_q  <= seen_d;
      pass_q  <= pass_d;
      abrt_q  <= abrt_d;
      done_q  <= done_d;
    end
  end

  assign x_out        = x_q;
  assign busy         = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done         = done_q;
  assign aborted      = abrt_q;
  assign pass         = pass_q;
  assign fail_cnt     = fcnt_q;
  assign first_fail_x = ffx_q;
  assign first_fail_y = ffy_q;
  assign fail_seen    = seen_q;

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Directed bench for skolem_sweep_ctrl: sweeps, failures, abort, reset.
// A second instance runs with zero settle cycles.
module tb_skolem_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] x_out;
  logic [1:0] y_in = 2'b10;
  logic       spec_ok;
  logic       busy, done, aborted, pass, fail_seen;
  logic [5:0] fail_cnt;
  logic [4:0] ffx;
  logic [1:0] ffy;

  logic       start0 = 1'b0;
  logic [4:0] x0;
  logic       busy0, done0, abrt0, pass0, seen0;
  logic [5:0] fcnt0;
  logic [4:0] ffx0;
  logic [1:0] ffy0;

  int mode = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n;
  int bad;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1: spec_ok = (x_out != 5'd19);
      2: spec_ok = 1'b0;
      3: spec_ok = (x_out != 5'd2);
      4: spec_ok = (x_out != 5'd7);
      default: spec_ok = 1'b1;
    endcase
  end

  skolem_sweep_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_out(x_out), .y_in(y_in), .spec_ok(spec_ok), .busy(busy),
    .done(done), .aborted(aborted), .pass(pass),
    .fail_cnt(fail_cnt), .first_fail_x(ffx),
    .first_fail_y(ffy), .fail_seen(fail_seen)
  );

  skolem_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
    .x_out(x0), .y_in(2'b01), .spec_ok(1'b0), .busy(busy0),
    .done(done0), .aborted(abrt0), .pass(pass0),
    .fail_cnt(fcnt0), .first_fail_x(ffx0),
    .first_fail_y(ffy0), .fail_seen(seen0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // cycles from the accepting edge until done is seen; -1 on timeout
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("reset_outs", {27'd0, busy, done, aborted, pass, fail_seen}, 0);
    chk("reset_vals", {19'd0, x_out, fail_cnt, ffx, ffy}, 0);
    rst_n = 1'b1;
    tick();

`ifndef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    // all pass
    mode = 0;
    go();
    chk("busy_after_start", busy, 1);
    wait_done(n);
    chk("done_latency", n, 65);
    chk("pass_all_ok", pass, 1);
    chk("fcnt_all_ok", fail_cnt, 0);
    chk("seen_all_ok", fail_seen, 0);
    chk("x_last", x_out, 31);
    tick();
    chk("done_one_cycle", done, 0);
    chk("x_hold_idle", x_out, 31);

    // single failure at x=19
    mode = 1;
    go();
    wait_done(n);
    chk("done_latency_f19", n, 65);
    chk("fcnt_f19", fail_cnt, 1);
    chk("ffx_f19", ffx, 19);
    chk("ffy_f19", ffy, 2);
    chk("pass_f19", pass, 0);
    chk("seen_f19", fail_seen, 1);

    // all fail, both instances
    mode = 2;
    start0 = 1'b1;
    go();
    start0 = 1'b0;
    wait_done(n);
    chk("fcnt_all_fail", fail_cnt, 32);
    chk("ffx_all_fail", ffx, 0);
    chk("pass_all_fail", pass, 0);
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done0) begin
        n = i;
        break;
      end
    end
    chk("s0_latency", n, 33);
    chk("s0_fcnt", fcnt0, 32);
    chk("s0_ffy", ffy0, 1);
    chk("s0_pass", pass0, 0);

    // abort ten cycles in, failure at x=2
    mode = 3;
    go();
    for (int i = 0; i < 9; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_flag", aborted, 1);
    chk("abort_fcnt", fail_cnt, 1);
    chk("abort_ffx", ffx, 2);
    chk("abort_pass", pass, 0);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done || busy) bad++;
    end
    chk("abort_no_done", bad, 0);
    go();
    chk("restart_aborted", aborted, 0);
    chk("restart_x", x_out, 0);
    chk("restart_fcnt", fail_cnt, 0);
    chk("restart_busy", busy, 1);
    wait_done(n);
    chk("restart_latency", n, 65);
    chk("restart_fcnt_end", fail_cnt, 1);

    // start with abort in IDLE
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_x", x_out, 31);
    chk("start_abort_fcnt", fail_cnt, 1);

    // start re-pulsed while busy
    mode = 0;
    go();
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      start = (i == 20);
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
    chk("restart_ignored", n, 65);
    chk("restart_ignored_pass", pass, 1);
`else
    // stop at first failure
    mode = 4;
    go();
    wait_done(n);
    chk("stop_latency", n, 17);
    chk("stop_fcnt", fail_cnt, 1);
    chk("stop_x", x_out, 7);
    chk("stop_ffx", ffx, 7);
    chk("stop_pass", pass, 0);
    chk("stop_seen", fail_seen, 1);
`endif

    // asynchronous reset mid-sweep
    tick();
    mode = 2;
    go();
    for (int i = 0; i < 19; i++) tick();
    chk("pre_reset_fcnt", fail_cnt, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_outs", {27'd0, busy, done, aborted, pass, fail_seen}, 0);
    chk("areset_vals", {19'd0, x_out, fail_cnt, ffx, ffy}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
